// File: rtl/ctrl_pipe_unit_if.sv
// Bundle of the signals between the IF/ID stage, the datapath pipeline
// registers and the control pipeline unit.
interface ctrl_pipe_unit_if #(
    parameter int CNT_W = 8
);
    logic [5:0]       opcode;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rt;
    logic             flush;
    logic             stall_req;
    logic [3:0]       ex_ctrl;
    logic [3:0]       m_ctrl;
    logic [1:0]       wb_ctrl;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output opcode, id_valid, id_rs, id_rt, ex_rt, flush,
        input  stall_req, ex_ctrl, m_ctrl, wb_ctrl, illegal, illegal_cnt
    );

    modport slave (
        input  opcode, id_valid, id_rs, id_rt, ex_rt, flush,
        output stall_req, ex_ctrl, m_ctrl, wb_ctrl, illegal, illegal_cnt
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// MIPS main-control decoder with registered ID/EX, EX/MEM and MEM/WB control
// stages, load-use bubble insertion, flush and illegal-opcode tracking.
module ctrl_pipe_unit #(
    parameter int MEM_LAT = 1,
    parameter bit EXT_EN  = 1'b1,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    ctrl_pipe_unit_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_NOP   = 6'b100000;

    logic [3:0]       dec_ex, dec_m;
    logic [1:0]       dec_wb;
    logic             dec_illegal;
    logic             stall;
    logic             illegal_d;
    logic [CNT_W-1:0] cnt_d;

    logic [3:0]       idex_ex_q, idex_m_q, exmem_m_q;
    logic [1:0]       idex_wb_q, exmem_wb_q;
    logic [1:0]       wb_q [MEM_LAT];
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    // Opcode decode; an invalid slot decodes to zero and is never illegal.
    always_comb begin
        dec_ex      = 4'b0000;
        dec_m       = 4'b0000;
        dec_wb      = 2'b00;
        dec_illegal = 1'b0;
        if (bus.id_valid) begin
            case (bus.opcode)
                OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; end
                OP_LW:    begin dec_ex = 4'b0001; dec_m = 4'b0010; dec_wb = 2'b11; end
                OP_SW:    begin dec_ex = 4'b0001; dec_m = 4'b0001; end
                OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 4'b0100; end
                OP_NOP:   ;
                OP_BNE: begin
                    if (EXT_EN) begin dec_ex = 4'b0010; dec_m = 4'b1000; end
                    else        dec_illegal = 1'b1;
                end
                OP_ADDI: begin
                    if (EXT_EN) begin dec_ex = 4'b0001; dec_wb = 2'b10; end
                    else        dec_illegal = 1'b1;
                end
                default:  dec_illegal = 1'b1;
            endcase
        end
    end

    // Load-use hazard against the load currently held in ID/EX (internal M field).
    always_comb begin
        stall = idex_m_q[1] & bus.id_valid & (bus.ex_rt != 5'd0) &
                ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
    end

    // An illegal opcode counts only when it actually enters ID/EX.
    always_comb begin
        illegal_d = dec_illegal & ~stall & ~bus.flush;
        cnt_d     = cnt_q;
        if (illegal_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Control pipeline: reset > flush > stall bubble > normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ex_q  <= '0;
            idex_m_q   <= '0;
            idex_wb_q  <= '0;
            exmem_m_q  <= '0;
            exmem_wb_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) wb_q[i] <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // Older instructions always drain through the WB chain.
            wb_q[0] <= exmem_wb_q;
            for (int i = 1; i < MEM_LAT; i++) wb_q[i] <= wb_q[i-1];
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            if (bus.flush) begin
                idex_ex_q  <= '0;
                idex_m_q   <= '0;
                idex_wb_q  <= '0;
                exmem_m_q  <= '0;
                exmem_wb_q <= '0;
            end else begin
                exmem_m_q  <= idex_m_q;
                exmem_wb_q <= idex_wb_q;
                if (stall) begin
                    idex_ex_q <= '0;
                    idex_m_q  <= '0;
                    idex_wb_q <= '0;
                end else begin
                    idex_ex_q <= dec_ex;
                    idex_m_q  <= dec_m;
                    idex_wb_q <= dec_wb;
                end
            end
        end
    end

    assign bus.stall_req   = stall;
    assign bus.ex_ctrl     = idex_ex_q;
    assign bus.m_ctrl      = exmem_m_q;
    assign bus.wb_ctrl     = wb_q[MEM_LAT-1];
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: one instance with the default
// configuration and one with MEM_LAT=3, EXT_EN=0, CNT_W=2.
module tb_ctrl_pipe_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.CNT_W(8)) ia ();
    ctrl_pipe_unit_if #(.CNT_W(2)) ib ();

    ctrl_pipe_unit #(.MEM_LAT(1), .EXT_EN(1'b1), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    ctrl_pipe_unit #(.MEM_LAT(3), .EXT_EN(1'b0), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] BAD   = 6'b111111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] xrt, input logic fl);
        ia.id_valid = v; ia.opcode = op; ia.id_rs = rs; ia.id_rt = rt;
        ia.ex_rt = xrt; ia.flush = fl;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [5:0] op);
        ib.id_valid = v; ib.opcode = op; ib.id_rs = 5'd0; ib.id_rt = 5'd0;
        ib.ex_rt = 5'd0; ib.flush = 1'b0;
        #1;
    endtask

    initial begin
        drive_a(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        drive_b(1'b0, RTYPE);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_ex", {28'd0, ia.ex_ctrl}, 32'h0);
        chk("rst_m", {28'd0, ia.m_ctrl}, 32'h0);
        chk("rst_wb", {30'd0, ia.wb_ctrl}, 32'h0);
        chk("rst_ill", {31'd0, ia.illegal}, 32'h0);
        chk("rst_cnt", {24'd0, ia.illegal_cnt}, 32'h0);

        // Back-to-back LW, RTYPE, SW, BEQ with MEM_LAT=1.
        drive_a(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        step(); chk("s1_ex", {28'd0, ia.ex_ctrl}, 32'b0001);
        drive_a(1'b1, RTYPE, 5'd3, 5'd4, 5'd0, 1'b0);
        step(); chk("s2_ex", {28'd0, ia.ex_ctrl}, 32'b1100);
                chk("s2_m", {28'd0, ia.m_ctrl}, 32'b0010);
        drive_a(1'b1, SW, 5'd3, 5'd4, 5'd0, 1'b0);
        step(); chk("s3_ex", {28'd0, ia.ex_ctrl}, 32'b0001);
                chk("s3_m", {28'd0, ia.m_ctrl}, 32'b0000);
                chk("s3_wb", {30'd0, ia.wb_ctrl}, 32'b11);
        drive_a(1'b1, BEQ, 5'd3, 5'd4, 5'd0, 1'b0);
        step(); chk("s4_ex", {28'd0, ia.ex_ctrl}, 32'b0010);
                chk("s4_m", {28'd0, ia.m_ctrl}, 32'b0001);
                chk("s4_wb", {30'd0, ia.wb_ctrl}, 32'b10);
        drive_a(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("s5_ex", {28'd0, ia.ex_ctrl}, 32'b0000);
                chk("s5_m", {28'd0, ia.m_ctrl}, 32'b0100);
                chk("s5_wb", {30'd0, ia.wb_ctrl}, 32'b00);
        step(); chk("s6_wb", {30'd0, ia.wb_ctrl}, 32'b00);
                chk("s6_ill", {31'd0, ia.illegal}, 32'h0);

        // Load-use hazard: LW rt=5 followed by RTYPE reading rs=5.
        drive_a(1'b1, LW, 5'd0, 5'd5, 5'd0, 1'b0);
        step();
        drive_a(1'b1, RTYPE, 5'd5, 5'd6, 5'd5, 1'b0);
        chk("hz_stall", {31'd0, ia.stall_req}, 32'h1);
        step(); chk("hz_bubble", {28'd0, ia.ex_ctrl}, 32'b0000);
                chk("hz_m_lw", {28'd0, ia.m_ctrl}, 32'b0010);
                chk("hz_stall_off", {31'd0, ia.stall_req}, 32'h0);
        step(); chk("hz_dep_ex", {28'd0, ia.ex_ctrl}, 32'b1100);
        // Same pattern with ex_rt=0 never stalls.
        drive_a(1'b1, LW, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive_a(1'b1, RTYPE, 5'd0, 5'd6, 5'd0, 1'b0);
        chk("hz0_stall", {31'd0, ia.stall_req}, 32'h0);
        step(); chk("hz0_ex", {28'd0, ia.ex_ctrl}, 32'b1100);
        // Match via rt instead of rs.
        drive_a(1'b1, LW, 5'd0, 5'd7, 5'd0, 1'b0);
        step();
        drive_a(1'b1, SW, 5'd1, 5'd7, 5'd7, 1'b0);
        chk("hzrt_stall", {31'd0, ia.stall_req}, 32'h1);

        // Flush during an RTYPE stream.
        drive_a(1'b1, RTYPE, 5'd1, 5'd2, 5'd0, 1'b0);
        step(); step();
        drive_a(1'b1, RTYPE, 5'd1, 5'd2, 5'd0, 1'b1);
        step(); chk("fl_ex", {28'd0, ia.ex_ctrl}, 32'b0000);
                chk("fl_m", {28'd0, ia.m_ctrl}, 32'b0000);
                chk("fl_wb", {30'd0, ia.wb_ctrl}, 32'b10);
        drive_a(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("fl_wb2", {30'd0, ia.wb_ctrl}, 32'b00);

        // Flush wins over a simultaneous stall: illegal opcode not counted.
        drive_a(1'b1, LW, 5'd0, 5'd9, 5'd0, 1'b0);
        step();
        drive_a(1'b1, BAD, 5'd9, 5'd0, 5'd9, 1'b1);
        chk("fs_stall", {31'd0, ia.stall_req}, 32'h1);
        step(); chk("fs_ex", {28'd0, ia.ex_ctrl}, 32'b0000);
                chk("fs_ill", {31'd0, ia.illegal}, 32'h0);
                chk("fs_cnt", {24'd0, ia.illegal_cnt}, 32'h0);

        // BNE decoded when extended opcodes are enabled.
        drive_a(1'b1, BNE, 5'd1, 5'd2, 5'd0, 1'b0);
        step(); chk("bne_ex", {28'd0, ia.ex_ctrl}, 32'b0010);
                chk("bne_ill", {31'd0, ia.illegal}, 32'h0);
        drive_a(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("bne_m", {28'd0, ia.m_ctrl}, 32'b1000);

        // Invalid slot with a garbage opcode is not illegal.
        drive_a(1'b0, BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("inv_ill", {31'd0, ia.illegal}, 32'h0);
        drive_a(1'b1, BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("bad_ill", {31'd0, ia.illegal}, 32'h1);
                chk("bad_cnt", {24'd0, ia.illegal_cnt}, 32'h1);
                chk("bad_ex", {28'd0, ia.ex_ctrl}, 32'h0);
        drive_a(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        step(); chk("bad_pulse", {31'd0, ia.illegal}, 32'h0);

        // Instance B: BNE is illegal with EXT_EN=0, counter saturates at 3.
        drive_b(1'b1, BNE);
        step(); chk("b_bne_ill", {31'd0, ib.illegal}, 32'h1);
                chk("b_cnt1", {30'd0, ib.illegal_cnt}, 32'd1);
                chk("b_bne_ex", {28'd0, ib.ex_ctrl}, 32'h0);
        drive_b(1'b0, RTYPE);
        step(); chk("b_pulse", {31'd0, ib.illegal}, 32'h0);
                chk("b_bne_m", {28'd0, ib.m_ctrl}, 32'h0);
        drive_b(1'b1, BAD);
        step(); chk("b_cnt2", {30'd0, ib.illegal_cnt}, 32'd2);
        step(); chk("b_cnt3", {30'd0, ib.illegal_cnt}, 32'd3);
        step(); chk("b_sat4", {30'd0, ib.illegal_cnt}, 32'd3);
        step(); chk("b_sat5", {30'd0, ib.illegal_cnt}, 32'd3);
                chk("b_ill_hold", {31'd0, ib.illegal}, 32'h1);

        // MEM_LAT=3: LW writeback control appears exactly at n+5.
        drive_b(1'b1, LW);
        step();
        drive_b(1'b0, RTYPE);
        step(); step(); step();
        chk("b_wb_n4", {30'd0, ib.wb_ctrl}, 32'b00);
        step(); chk("b_wb_n5", {30'd0, ib.wb_ctrl}, 32'b11);
        step(); chk("b_wb_n6", {30'd0, ib.wb_ctrl}, 32'b00);

        // Reset during cycle n+3 discards the in-flight LW.
        drive_b(1'b1, LW);
        step();
        drive_b(1'b0, RTYPE);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b_rst_n4", {30'd0, ib.wb_ctrl}, 32'b00);
        chk("b_rst_cnt", {30'd0, ib.illegal_cnt}, 32'd0);
        step(); chk("b_rst_n5", {30'd0, ib.wb_ctrl}, 32'b00);
        step(); chk("b_rst_n6", {30'd0, ib.wb_ctrl}, 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the combinational main-control decoder of the MIPS pipeline.
- Decodes the ID-stage opcode, then carries EX/M/WB control fields through registered ID/EX, EX/MEM and MEM/WB stages.
- Supports a configurable memory latency, optional extended opcodes (ADDI, BNE), load-use hazard detection with bubble insertion, flush, and illegal-opcode tracking.
- Sits between the IF/ID register and the datapath pipeline registers.

Parameters:
- MEM_LAT, 1, number of register stages from the EX/MEM control output to the wb_ctrl output (1..3).
- EXT_EN, 1, 1 = decode ADDI (001000) and BNE (000101); 0 = treat them as illegal.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from IF/ID
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  5  ID-stage rs field
- id_rt  in  5  ID-stage rt field
- ex_rt  in  5  rt field currently held in the ID/EX datapath register
- flush  in  1  branch/jump taken; kill the younger instructions
- stall_req  out  1  load-use hazard: hold PC and IF/ID (combinational)
- ex_ctrl  out  4  ID/EX control {RegDst, ALUOp1, ALUOp0, ALUSrc}
- m_ctrl  out  4  EX/MEM control {BranchNe, Branch, MemRead, MemWrite}
- wb_ctrl  out  2  final MEM/WB control {RegWrite, MemtoReg}
- illegal  out  1  one-cycle pulse for a decoded illegal opcode
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Decode table (EX / M / WB):
  - RTYPE 000000: 1100 / 0000 / 10
  - LW 100011: 0001 / 0010 / 11
  - SW 101011: 0001 / 0001 / 00
  - BEQ 000100: 0010 / 0100 / 00
  - BNE: 0010 / 1000 / 00
  - ADDI: 0001 / 0000 / 10
  - NOP 100000: all zero
- Don't-care bits are driven 0. No output is ever X or Z.
- Any other opcode, or BNE/ADDI with EXT_EN=0: decodes to all-zero controls and is flagged illegal.
- id_valid=0: decodes to all-zero controls; never flagged illegal.
- Hazard detection (combinational):
  - stall_req = ID/EX MemRead & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - ID/EX MemRead is the MemRead bit of the internally held M field, not of m_ctrl.
- Each rising clk edge, priority order:
  1. rst: every pipeline register, illegal and illegal_cnt go to 0.
  2. flush: the ID/EX register (EX, M, WB fields) and the EX/MEM register load zero. The WB chain still advances and takes the old EX/MEM WB field, so older instructions complete.
  3. stall_req: the ID/EX register loads zero (bubble). EX/MEM and later stages advance normally.
  4. Otherwise all stages advance: ID/EX <- decode; EX/MEM <- ID/EX M and WB fields; WB chain shifts.
- Latency for an instruction decoded in cycle n:
  - ex_ctrl valid at n+1
  - m_ctrl valid at n+2
  - wb_ctrl valid at n+2+MEM_LAT
- illegal:
  - Registered. Asserted at n+1 when cycle n had id_valid=1, an illegal opcode, no stall_req and no flush.
  - It is a one-cycle pulse per decode.
  - A stalled illegal instruction is counted only on the cycle it actually enters ID/EX.
- illegal_cnt: increments on every illegal pulse and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous flush and stall_req: flush wins. stall_req is still driven combinationally; the datapath may honour it harmlessly.
- Reset mid-stream: all in-flight controls are discarded. wb_ctrl=00 the cycle after rst and stays 00 until new instructions drain through.

Test Plan:
- Reset, then send LW, RTYPE, SW, BEQ back-to-back with id_valid=1, MEM_LAT=1 -> ex_ctrl 0001,1100,0001,0010 on cycles 1-4; m_ctrl 0010,0000,0001,0100 on cycles 2-5; wb_ctrl 11,10,00,00 on cycles 3-6.
- LW with ex_rt=5, next instruction id_rs=5 -> stall_req=1 for exactly one cycle; ex_ctrl=0000 bubble the next cycle; the dependent RTYPE then appears with ex_ctrl=1100. Repeat with ex_rt=0 -> no stall.
- Assert flush during a stream of RTYPEs -> ex_ctrl=0000 and m_ctrl=0000 on the next edge; wb_ctrl still shows 10 for the instruction that was already in EX/MEM.
- EXT_EN=0, opcode 000101 -> illegal pulses once, illegal_cnt=1, all controls zero. EXT_EN=1 -> m_ctrl=1000, no pulse.
- CNT_W=2, feed 5 illegal opcodes -> illegal_cnt goes 1,2,3,3,3.
- MEM_LAT=3, LW -> wb_ctrl=11 exactly at cycle n+5. Assert rst at n+3 -> wb_ctrl stays 00.
